// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU calculator: opcodes, FSM state encodings
// and flag bit positions.
package alu_seq_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        S_OP_A   = 3'd0,
        S_OP_B   = 3'd1,
        S_OPCODE = 3'd2,
        S_EXEC   = 3'd3,
        S_SHOW   = 3'd4
    } state_t;

    localparam int unsigned FLAG_ZERO = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF = 2;
    localparam int unsigned FLAG_ERR = 3;

endpackage

// File: rtl/alu_seq_calc_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, saturating stable-high counter and
// rising-edge detect producing one pulse per accepted press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(DEBOUNCE_CYCLES);

    logic              r_sync1;
    logic              r_sync2;
    logic [NB_CNT-1:0] r_count;
    logic              r_level;
    logic              w_level;

    assign w_level = (r_count == CNT_MAX);
    assign o_pulse = w_level & ~r_level;

    always_ff @(posedge i_clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_count <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_level <= w_level;
            if (!r_sync2) begin
                r_count <= '0;
            end else if (!w_level) begin
                r_count <= r_count + NB_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq_calc.sv
// Sequential ALU calculator: ENTER steps through A / B / opcode capture, then executes.
// Optional macro ALU_SEQ_CHAIN_EN: ENTER in S_SHOW feeds the result back as A.
module alu_seq_calc #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned NB_OPCODE       = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned NB_STATE        = 3
) (
    input  logic                i_clock,
    input  logic                reset,
    input  logic [NB_DATA-1:0]  i_switch,
    input  logic                i_btn_enter,
    input  logic                i_btn_clear,
    output logic [NB_DATA-1:0]  o_led,
    output logic                o_result_valid,
    output logic [3:0]          o_flags,
    output logic [NB_STATE-1:0] o_state
);

    import alu_seq_pkg::*;

    localparam int unsigned NB_SHIFT = $clog2(NB_DATA);

    state_t               r_state;
    state_t               w_state_next;
    logic [NB_DATA-1:0]   r_a;
    logic [NB_DATA-1:0]   r_b;
    logic [NB_OPCODE-1:0] r_opcode;
    logic [NB_DATA-1:0]   r_led;
    logic [3:0]           r_flags;
    logic                 r_valid;
    logic                 w_enter;
    logic                 w_clear;
    logic [NB_DATA:0]     w_sum;
    logic [NB_DATA:0]     w_diff;
    logic [NB_SHIFT-1:0]  w_shamt;
    logic [NB_DATA-1:0]   w_result;
    logic [3:0]           w_flags;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_enter (
        .i_clock(i_clock),
        .reset  (reset),
        .i_btn  (i_btn_enter),
        .o_pulse(w_enter)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_clear (
        .i_clock(i_clock),
        .reset  (reset),
        .i_btn  (i_btn_clear),
        .o_pulse(w_clear)
    );

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
    assign w_shamt = r_b[NB_SHIFT-1:0];

    always_comb begin
        w_result = '0;
        w_flags  = '0;
        case (r_opcode)
            NB_OPCODE'(OP_ADD): begin
                w_result            = w_sum[NB_DATA-1:0];
                w_flags[FLAG_CARRY] = w_sum[NB_DATA];
                w_flags[FLAG_OVF]   = (r_a[NB_DATA-1] == r_b[NB_DATA-1]) &&
                                      (w_sum[NB_DATA-1] != r_a[NB_DATA-1]);
            end
            NB_OPCODE'(OP_SUB): begin
                w_result            = w_diff[NB_DATA-1:0];
                w_flags[FLAG_CARRY] = w_diff[NB_DATA];  // borrow, i.e. A < B unsigned
                w_flags[FLAG_OVF]   = (r_a[NB_DATA-1] != r_b[NB_DATA-1]) &&
                                      (w_diff[NB_DATA-1] != r_a[NB_DATA-1]);
            end
            NB_OPCODE'(OP_AND): w_result = r_a & r_b;
            NB_OPCODE'(OP_OR):  w_result = r_a | r_b;
            NB_OPCODE'(OP_XOR): w_result = r_a ^ r_b;
            NB_OPCODE'(OP_NOR): w_result = ~(r_a | r_b);
            NB_OPCODE'(OP_SRA): w_result = $signed(r_a) >>> w_shamt;
            NB_OPCODE'(OP_SRL): w_result = r_a >> w_shamt;
            default:            w_flags[FLAG_ERR] = 1'b1;
        endcase
        w_flags[FLAG_ZERO] = (w_result == '0);
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clear) begin
            w_state_next = S_OP_A;
        end else begin
            case (r_state)
                S_OP_A:   if (w_enter) w_state_next = S_OP_B;
                S_OP_B:   if (w_enter) w_state_next = S_OPCODE;
                S_OPCODE: if (w_enter) w_state_next = S_EXEC;
                S_EXEC:   w_state_next = S_SHOW;
                S_SHOW: begin
`ifdef ALU_SEQ_CHAIN_EN
                    if (w_enter) w_state_next = S_OP_B;
`else
                    if (w_enter) w_state_next = S_OP_A;
`endif
                end
                default:  w_state_next = S_OP_A;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (reset) begin
            r_state <= S_OP_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clock) begin
        if (reset || w_clear) begin
            r_a      <= '0;
            r_b      <= '0;
            r_opcode <= '0;
            r_led    <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_OP_A:   if (w_enter) r_a <= i_switch;
                S_OP_B:   if (w_enter) r_b <= i_switch;
                S_OPCODE: if (w_enter) r_opcode <= i_switch[NB_OPCODE-1:0];
                S_EXEC: begin
                    r_led   <= w_result;
                    r_flags <= w_flags;
                    r_valid <= 1'b1;
                end
                S_SHOW: begin
`ifdef ALU_SEQ_CHAIN_EN
                    if (w_enter) r_a <= r_led;
`else
                    if (w_enter) r_valid <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_led          = r_led;
    assign o_flags        = r_flags;
    assign o_result_valid = r_valid;
    assign o_state        = NB_STATE'(r_state);

endmodule

// File: tb/tb_alu_seq_calc.sv
// Randomised self-checking bench for alu_seq_calc against an arithmetic reference model.
module tb_alu_seq_calc;

    localparam int DB = 4;

    logic       i_clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_switch = 8'h00;
    logic       i_btn_enter = 1'b0;
    logic       i_btn_clear = 1'b0;
    logic [7:0] o_led;
    logic       o_result_valid;
    logic [3:0] o_flags;
    logic [2:0] o_state;

    int checks = 0;
    int errors = 0;

    alu_seq_calc #(
        .NB_DATA        (8),
        .NB_OPCODE      (6),
        .DEBOUNCE_CYCLES(DB),
        .NB_STATE       (3)
    ) dut (
        .i_clock       (i_clock),
        .reset         (reset),
        .i_switch      (i_switch),
        .i_btn_enter   (i_btn_enter),
        .i_btn_clear   (i_btn_clear),
        .o_led         (o_led),
        .o_result_valid(o_result_valid),
        .o_flags       (o_flags),
        .o_state       (o_state)
    );

    always #5 i_clock = ~i_clock;

    // Returns {error, overflow, carry, zero, result[7:0]}.
    function automatic logic [11:0] model(input int a, input int b, input int op);
        int r, sa, sb, s, sh;
        bit c, v, e;
        c = 0; v = 0; e = 0; r = 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        sh = b % 8;
        case (op)
            32: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            34: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = ~(a | b);
            3:  r = sa >>> sh;
            2:  r = a >> sh;
            default: begin r = 0; e = 1; end
        endcase
        r = r & 255;
        return {e, v, c, (r == 0), 8'(r)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    // Clean press of ENTER (optionally CLEAR too); also checks that EXEC lasts one cycle.
    task automatic press(input logic [7:0] val, input bit with_clear);
        logic [2:0] prev;
        i_switch = val;
        i_btn_enter = 1'b1;
        i_btn_clear = with_clear;
        prev = o_state;
        for (int k = 0; k < DB + 14; k++) begin
            if (k == DB + 8) begin
                i_btn_enter = 1'b0;
                i_btn_clear = 1'b0;
            end
            @(negedge i_clock);
            if (prev == 3'd3) begin
                checks++;
                if (o_state !== 3'd4 || o_result_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL exec_one_cycle: state=%0d valid=%b, required state=4 valid=1",
                             o_state, o_result_valid);
                end
            end
            prev = o_state;
        end
    endtask

    task automatic press_clear();
        i_btn_clear = 1'b1;
        cyc(DB + 8);
        i_btn_clear = 1'b0;
        cyc(DB + 6);
    endtask

    task automatic check_state(input string name, input logic [2:0] exp);
        checks++;
        if (o_state !== exp) begin
            errors++;
            $display("FAIL %s: state=%0d required=%0d", name, o_state, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [5:0] op);
        logic [11:0] exp;
        exp = model(int'(a), int'(b), int'(op));
        press(a, 0);
        check_state({name, "_opa"}, 3'd1);
        press(b, 0);
        check_state({name, "_opb"}, 3'd2);
        press({2'b00, op}, 0);
        checks++;
        if (o_led !== exp[7:0] || o_flags !== exp[11:8] || o_result_valid !== 1'b1 ||
            o_state !== 3'd4) begin
            errors++;
            $display("FAIL %s: a=%h b=%h op=%b led=%h flags=%b valid=%b state=%0d, required led=%h flags=%b valid=1 state=4",
                     name, a, b, op, o_led, o_flags, o_result_valid, o_state, exp[7:0], exp[11:8]);
        end
`ifdef ALU_SEQ_CHAIN_EN
        press_clear();
`else
        press(8'h00, 0);
        checks++;
        if (o_state !== 3'd0 || o_result_valid !== 1'b0 || o_led !== exp[7:0]) begin
            errors++;
            $display("FAIL %s_show_exit: state=%0d valid=%b led=%h, required state=0 valid=0 led=%h",
                     name, o_state, o_result_valid, o_led, exp[7:0]);
        end
`endif
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_led !== 8'h00 || o_flags !== 4'h0 || o_result_valid !== 1'b0 || o_state !== 3'd0) begin
            errors++;
            $display("FAIL reset: led=%h flags=%b valid=%b state=%0d, required all zero",
                     o_led, o_flags, o_result_valid, o_state);
        end
    endtask

    task automatic test_bounce();
        int changes;
        logic [2:0] prev;
        changes = 0;
        prev = o_state;
        i_switch = 8'h5A;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                i_btn_enter = (k < 3);
                @(negedge i_clock);
                if (o_state !== prev) changes++;
                prev = o_state;
            end
        end
        check_state("bounce_reject", 3'd0);
        i_btn_enter = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 20) i_btn_enter = 1'b0;
            @(negedge i_clock);
            if (o_state !== prev) changes++;
            prev = o_state;
        end
        checks++;
        if (changes != 1) begin
            errors++;
            $display("FAIL bounce_pulses: state changes=%0d required=1", changes);
        end
        check_state("bounce_state", 3'd1);
    endtask

    task automatic test_clear();
        press_clear();
        check_state("clear_from_opb", 3'd0);
    endtask

    task automatic test_clear_priority();
        press(8'h11, 0);
        press(8'h22, 0);
        check_state("clrpri_setup", 3'd2);
        press(8'h20, 1);
        checks++;
        if (o_state !== 3'd0 || o_led !== 8'h00 || o_result_valid !== 1'b0 || o_flags !== 4'h0) begin
            errors++;
            $display("FAIL clear_priority: state=%0d led=%h valid=%b flags=%b, required 0/00/0/0000",
                     o_state, o_led, o_result_valid, o_flags);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b000011, 6'b000010};
        logic [5:0] op;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 7)];
            run_op("random", 8'($urandom), 8'($urandom), op);
        end
    endtask

    task automatic test_reset_mid_debounce();
        check_state("rmd_pre", 3'd0);
        i_switch = 8'h33;
        i_btn_enter = 1'b1;
        cyc(DB + 1);
        reset = 1'b1;
        i_btn_enter = 1'b0;
        cyc(1);
        reset = 1'b0;
        cyc(DB + 10);
        check_state("reset_mid_debounce", 3'd0);
    endtask

`ifdef ALU_SEQ_CHAIN_EN
    task automatic test_chain();
        press(8'h03, 0);
        press(8'h04, 0);
        press(8'h20, 0);
        press(8'h00, 0);
        checks++;
        if (o_state !== 3'd1 || o_result_valid !== 1'b1) begin
            errors++;
            $display("FAIL chain_enter: state=%0d valid=%b required state=1 valid=1",
                     o_state, o_result_valid);
        end
        press(8'h01, 0);
        press(8'h20, 0);
        checks++;
        if (o_led !== 8'h08) begin
            errors++;
            $display("FAIL chain_result: led=%h required=08", o_led);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_bounce();
        test_clear();
        run_op("add_carry", 8'hF0, 8'h20, 6'b100000);
        test_clear_priority();
        run_op("sub_ovf", 8'h80, 8'h01, 6'b100010);
        run_op("sub_zero", 8'h05, 8'h05, 6'b100010);
        run_op("sra", 8'h90, 8'h02, 6'b000011);
        run_op("invalid", 8'h12, 8'h34, 6'b111111);
        test_random();
        test_reset_mid_debounce();
`ifdef ALU_SEQ_CHAIN_EN
        test_chain();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq_calc.md
Name: alu_seq_calc

Overview:
- Parametrised successor of the board-level ALU calculator.
- A single debounced ENTER button walks an FSM that captures operand A, operand B and opcode from the switches, then executes.
- The result is registered with status flags (zero, carry, overflow, error). A CLEAR button aborts at any point.
- Sits between the board I/O (switches, buttons, LEDs) and the ALU datapath. Replaces the three-button free-running capture scheme.

Parameters:
- NB_DATA, default 8: operand/result width (minimum 4).
- NB_OPCODE, default 6: opcode field width, taken from i_switch[NB_OPCODE-1:0].
- DEBOUNCE_CYCLES, default 1000000: consecutive stable-high cycles required to accept a button press (10 ms at 100 MHz).
- NB_STATE, default 3: width of the o_state debug output.

Ports:
- i_clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_switch  in  NB_DATA  operand/opcode entry switches
- i_btn_enter  in  1  raw ENTER button (asynchronous, bouncing)
- i_btn_clear  in  1  raw CLEAR button (asynchronous, bouncing)
- o_led  out  NB_DATA  registered result
- o_result_valid  out  1  high while a computed result is displayed
- o_flags  out  4  {error, overflow, carry, zero}, registered
- o_state  out  NB_STATE  current FSM state encoding, for debug LEDs

Behaviour:
- Reset is synchronous and active-high on i_clock. After reset:
  - o_led = 0, o_flags = 0, o_result_valid = 0.
  - Internal A, B and opcode registers = 0.
  - State = S_OP_A.
- Button conditioning, per button:
  - 2-flop synchroniser feeds a counter.
  - Counter increments while the synchronised input is high and saturates at DEBOUNCE_CYCLES. It clears whenever the input is low.
  - Debounced level = counter at saturation.
  - Press pulse = rising edge of the debounced level: exactly one cycle per press, regardless of hold time.
- FSM states and encodings:
  - S_OP_A = 0, S_OP_B = 1, S_OPCODE = 2, S_EXEC = 3, S_SHOW = 4.
- Transitions:
  - S_OP_A: enter pulse → A <= i_switch, go to S_OP_B.
  - S_OP_B: enter pulse → B <= i_switch, go to S_OPCODE.
  - S_OPCODE: enter pulse → opcode <= i_switch[NB_OPCODE-1:0], go to S_EXEC.
  - S_EXEC: lasts one cycle unconditionally. Result and flags are registered; o_result_valid <= 1; go to S_SHOW.
  - S_SHOW: hold the result. An enter pulse goes to S_OP_A and clears o_result_valid. o_led keeps its last value until the next S_EXEC.
- Clear pulse in any state:
  - Returns to S_OP_A.
  - Zeroes A, B, opcode, o_led, o_flags and o_result_valid.
  - Clear has priority over a simultaneous enter pulse.
- Reset overrides everything, including mid-debounce: the counters clear.
- Latency:
  - Synchronised edge to press pulse = 2 + DEBOUNCE_CYCLES cycles.
  - Opcode capture to o_result_valid = 2 cycles.
- Opcodes (MIPS funct codes), all unsigned wrap at NB_DATA:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SRA 000011 and SRL 000010: shift amount = B[$clog2(NB_DATA)-1:0]; SRA is arithmetic on signed A.
- Flags:
  - zero = (result == 0).
  - carry: ADD → carry-out of bit NB_DATA-1; SUB → borrow, i.e. (A < B unsigned); all other ops → 0.
  - overflow: signed overflow for ADD/SUB only, else 0.
  - error: opcode not in the list above; result forced to 0, zero flag = 1.

Optional Feature:
- Macro ALU_SEQ_CHAIN_EN.
- When defined:
  - An enter pulse in S_SHOW loads A <= current result, keeps o_result_valid = 1, and goes to S_OP_B (accumulator chaining).
  - Clear still returns to S_OP_A.
- When undefined, S_SHOW + enter behaves as specified above (go to S_OP_A).

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD … OP_SRL)
  - state encodings (S_OP_A … S_SHOW)
  - flag bit indices (FLAG_ZERO = 0, FLAG_CARRY = 1, FLAG_OVF = 2, FLAG_ERR = 3).
- One sub-module, btn_debounce (synchroniser, counter, edge detect), instantiated twice.
- The ALU datapath stays combinational inside this block.

Test Plan (DEBOUNCE_CYCLES = 4, NB_DATA = 8):
- Bounce rejection: ENTER toggled high 3 cycles / low 1 cycle, repeated 10 times, then held high 20 cycles → exactly one press pulse; state 0→1.
- ADD with carry: A = 0xF0, B = 0x20, op 100000 → o_led = 0x10, flags = 0b0010, o_result_valid = 1 two cycles after opcode capture.
- SUB overflow: A = 0x80, B = 0x01, op 100010 → o_led = 0x7F, overflow = 1, carry = 0; then A = 0x05, B = 0x05 → o_led = 0x00, zero = 1.
- SRA: A = 0x90, B = 0x02, op 000011 → o_led = 0xE4. Invalid op 111111 → o_led = 0x00, flags = 0b1001.
- Clear priority: ENTER and CLEAR pulses in the same cycle while in S_OPCODE → state 0, o_led = 0, o_result_valid = 0. Reset asserted mid-debounce → no pulse afterwards.
- With ALU_SEQ_CHAIN_EN: 0x03 + 0x04 = 0x07, enter, B = 0x01, ADD → o_led = 0x08 without re-entering A.
